// File: rtl/rv32_pkg.sv
// Shared RV32 definitions for the load/store path: MemOp encodings,
// the LSU state encoding and the access alignment check.
package rv32_pkg;

  localparam logic [2:0] MEMOP_B  = 3'b000;
  localparam logic [2:0] MEMOP_BU = 3'b001;
  localparam logic [2:0] MEMOP_H  = 3'b010;
  localparam logic [2:0] MEMOP_HU = 3'b011;
  localparam logic [2:0] MEMOP_W  = 3'b100;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_REQ,
    LSU_WAIT,
    LSU_DONE
  } lsu_state_e;

  // An access faults when its MemOp is not a known size, or when the byte
  // address is not a multiple of the access size.
  function automatic logic lsuMisaligned(input logic [2:0] memOp, input logic [1:0] addrLo);
    logic bad;
    case (memOp)
      MEMOP_B, MEMOP_BU: bad = 1'b0;
      MEMOP_H, MEMOP_HU: bad = addrLo[0];
      MEMOP_W:           bad = |addrLo;
      default:           bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Word-addressed data-memory handshake: request/grant for the access,
// then a separate read-valid response for loads.
interface load_store_unit_if #(parameter int ADDR_W = 32);

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/lsu_align.sv
// Lane steering for the LSU: byte enables and replicated store data on the
// way out, shift plus sign/zero extension of the read word on the way back.
module lsu_align
  import rv32_pkg::*;
(
  input  logic [2:0]  memOp_i,
  input  logic [1:0]  addrLo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] memRdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_o
);

  logic [31:0] shifted;

  // Bring the addressed byte lane down to bit 0.
  assign shifted = memRdata_i >> {addrLo_i, 3'b000};

  // Store side: enable only the touched lanes and copy the data onto every lane.
  always_comb begin
    be_o    = 4'b1111;
    wdata_o = wdata_i;
    case (memOp_i)
      MEMOP_B, MEMOP_BU: begin
        be_o    = 4'b0001 << addrLo_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      MEMOP_H, MEMOP_HU: begin
        be_o    = 4'b0011 << addrLo_i;
        wdata_o = {2{wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Load side: extend the shifted value from its top bit; words pass unchanged.
  always_comb begin
    load_o = memRdata_i;
    case (memOp_i)
      MEMOP_B:  load_o = {{24{shifted[7]}}, shifted[7:0]};
      MEMOP_BU: load_o = {24'b0, shifted[7:0]};
      MEMOP_H:  load_o = {{16{shifted[15]}}, shifted[15:0]};
      MEMOP_HU: load_o = {16'b0, shifted[15:0]};
      default:  load_o = memRdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Executes one RV32I load or store per start pulse against a word-addressed
// data memory, faulting misaligned or illegal requests without touching memory.
module load_store_unit
  import rv32_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              MemWr,
  input  logic [2:0]        MemOp,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic [31:0]       rdata,
  load_store_unit_if.master mem
);

  lsu_state_e        state_q;
  logic [2:0]        memOp_q;
  logic [1:0]        addrLo_q;
  logic              busy_q;
  logic              done_q;
  logic              fault_q;
  logic [31:0]       rdata_q;
  logic              memReq_q;
  logic              memWe_q;
  logic [ADDR_W-1:0] memAddr_q;
  logic [3:0]        memBe_q;
  logic [31:0]       memWdata_q;

  logic [2:0]        alignOp;
  logic [1:0]        alignLo;
  logic [3:0]        alignBe;
  logic [31:0]       alignWdata;
  logic [31:0]       alignLoad;

  // In IDLE the steering works on the incoming request so its lanes can be
  // registered at accept; afterwards it works on the captured request so the
  // load extract sees the original MemOp and address.
  assign alignOp = (state_q == LSU_IDLE) ? MemOp     : memOp_q;
  assign alignLo = (state_q == LSU_IDLE) ? addr[1:0] : addrLo_q;

  lsu_align u_align (
    .memOp_i    (alignOp),
    .addrLo_i   (alignLo),
    .wdata_i    (wdata),
    .memRdata_i (mem.mem_rdata),
    .be_o       (alignBe),
    .wdata_o    (alignWdata),
    .load_o     (alignLoad)
  );

  // Control FSM; every output is a register so the memory side sees stable values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LSU_IDLE;
      memOp_q    <= 3'b000;
      addrLo_q   <= 2'b00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fault_q    <= 1'b0;
      rdata_q    <= 32'b0;
      memReq_q   <= 1'b0;
      memWe_q    <= 1'b0;
      memAddr_q  <= '0;
      memBe_q    <= 4'b0;
      memWdata_q <= 32'b0;
    end else begin
      case (state_q)
        LSU_IDLE: begin
          if (start) begin
            memOp_q  <= MemOp;
            addrLo_q <= addr[1:0];
            busy_q   <= 1'b1;
            if (lsuMisaligned(MemOp, addr[1:0])) begin
              state_q <= LSU_DONE;
              done_q  <= 1'b1;
              fault_q <= 1'b1;
            end else begin
              state_q    <= LSU_REQ;
              memReq_q   <= 1'b1;
              memWe_q    <= MemWr;
              memAddr_q  <= {addr[ADDR_W-1:2], 2'b00};
              memBe_q    <= alignBe;
              memWdata_q <= alignWdata;
            end
          end
        end
        LSU_REQ: begin
          if (mem.mem_gnt) begin
            memReq_q <= 1'b0;
            memWe_q  <= 1'b0;
            if (memWe_q) begin
              state_q <= LSU_DONE;
              done_q  <= 1'b1;
              fault_q <= 1'b0;
            end else begin
              state_q <= LSU_WAIT;
            end
          end
        end
        LSU_WAIT: begin
          if (mem.mem_rvalid) begin
            rdata_q <= alignLoad;
            state_q <= LSU_DONE;
            done_q  <= 1'b1;
            fault_q <= 1'b0;
          end
        end
        LSU_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= LSU_IDLE;
        end
        default: state_q <= LSU_IDLE;
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign fault         = fault_q;
  assign rdata         = rdata_q;
  assign mem.mem_req   = memReq_q;
  assign mem.mem_we    = memWe_q;
  assign mem.mem_addr  = memAddr_q;
  assign mem.mem_be    = memBe_q;
  assign mem.mem_wdata = memWdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a transaction-level model predicts every
// output each cycle, and literal checks pin the headline cases.
module tb_load_store_unit;
  import rv32_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        MemWr = 1'b0;
  logic [2:0]  MemOp = 3'b000;
  logic [31:0] addr = 32'b0;
  logic [31:0] wdata = 32'b0;
  logic        busy, done, fault;
  logic [31:0] rdata;

  load_store_unit_if #(.ADDR_W(32)) memIf ();

  load_store_unit #(.ADDR_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .MemWr (MemWr),
    .MemOp (MemOp),
    .addr  (addr),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .fault (fault),
    .rdata (rdata),
    .mem   (memIf)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;
  int lastDoneCycle = -1;
  int startCycle = 0;
  logic checkEn = 1'b0;
  logic reqSeen = 1'b0;

  logic        eBusy = 1'b0, eDone = 1'b0, eFault = 1'b0, eReq = 1'b0, eWe = 1'b0;
  logic [31:0] eRdata = 32'b0, eAddr = 32'b0, eWdata = 32'b0;
  logic [3:0]  eBe = 4'b0;

  logic [31:0] capAddr, capWdata;
  logic [3:0]  capBe;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s at cycle %0d: got %h, required %h", name, cycle, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  // Access size in bytes; zero marks an illegal MemOp.
  function automatic int opBytes(input logic [2:0] op);
    case (op)
      3'd0, 3'd1: return 1;
      3'd2, 3'd3: return 2;
      3'd4:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic logic modelFault(input logic [2:0] op, input int lo);
    int n;
    n = opBytes(op);
    return (n == 0) || ((lo % n) != 0);
  endfunction

  function automatic logic [3:0] modelBe(input logic [2:0] op, input int lo);
    logic [31:0] m;
    m = ((32'd1 << opBytes(op)) - 32'd1) << lo;
    return m[3:0];
  endfunction

  function automatic logic [31:0] modelWdata(input logic [2:0] op, input logic [31:0] wd);
    logic [31:0] r;
    int n;
    n = opBytes(op);
    r = 32'b0;
    for (int lane = 0; lane < 4; lane++) r[8*lane +: 8] = wd[8*(lane % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] modelLoad(input logic [2:0] op, input int lo, input logic [31:0] rd);
    int n;
    longint m, v;
    logic [63:0] bits;
    n = opBytes(op);
    if (n == 4) return rd;
    m = longint'(1) << (8 * n);
    v = longint'(rd >> (8 * lo)) % m;
    if ((op == 3'd0 || op == 3'd2) && v >= m / 2) v = v - m;
    bits = 64'(v);
    return bits[31:0];
  endfunction

  // Every cycle after reset release, hold all outputs against the model.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("busy", 32'(busy), 32'(eBusy));
      checkOutput("done", 32'(done), 32'(eDone));
      checkOutput("fault", 32'(fault), 32'(eFault));
      checkOutput("rdata", rdata, eRdata);
      checkOutput("mem_req", 32'(memIf.mem_req), 32'(eReq));
      if (eReq) begin
        checkOutput("mem_we", 32'(memIf.mem_we), 32'(eWe));
        checkOutput("mem_addr", memIf.mem_addr, eAddr);
        checkOutput("mem_be", 32'(memIf.mem_be), 32'(eBe));
        if (eWe) checkOutput("mem_wdata", memIf.mem_wdata, eWdata);
      end
    end
    if (done) lastDoneCycle = cycle;
    if (memIf.mem_req) reqSeen = 1'b1;
  end

  // One complete access: start pulse, optional grant stall, read response, done.
  task automatic applyStimulus(input logic wr, input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] wd, input int gntDelay, input int rvDelay,
                               input logic [31:0] rd, input logic stallStart);
    int lo;
    lo = int'(a[1:0]);
    startCycle = cycle;
    MemWr = wr; MemOp = op; addr = a; wdata = wd; start = 1'b1;
    step();
    start = 1'b0; MemWr = ~wr; MemOp = 3'b110; addr = 32'hFFFF_FFFF; wdata = 32'h5A5A_5A5A;
    eBusy = 1'b1;
    if (modelFault(op, lo)) begin
      eDone = 1'b1; eFault = 1'b1;
      step();
      eDone = 1'b0; eBusy = 1'b0;
      return;
    end
    eReq = 1'b1; eWe = wr; eAddr = {a[31:2], 2'b00};
    eBe = modelBe(op, lo); eWdata = modelWdata(op, wd);
    capAddr = memIf.mem_addr; capBe = memIf.mem_be; capWdata = memIf.mem_wdata;
    for (int g = 0; g < gntDelay; g++) begin
      memIf.mem_gnt = 1'b0;
      memIf.mem_rvalid = ~wr;
      memIf.mem_rdata = 32'h1357_9BDF;
      if (stallStart && g == 1) begin
        start = 1'b1; MemWr = 1'b0; MemOp = MEMOP_W; addr = 32'h0000_7770;
      end
      step();
      start = 1'b0;
    end
    memIf.mem_rvalid = 1'b0;
    memIf.mem_gnt = 1'b1;
    step();
    memIf.mem_gnt = 1'b0;
    eReq = 1'b0; eWe = 1'b0;
    if (!wr) begin
      for (int i = 1; i < rvDelay; i++) step();
      memIf.mem_rvalid = 1'b1;
      memIf.mem_rdata = rd;
      step();
      memIf.mem_rvalid = 1'b0;
      memIf.mem_rdata = 32'hA0A0_A0A0;
      eRdata = modelLoad(op, lo, rd);
    end
    eDone = 1'b1; eFault = 1'b0;
    step();
    eDone = 1'b0; eBusy = 1'b0;
  endtask

  initial begin
    int firstDone;
    memIf.mem_gnt = 1'b0;
    memIf.mem_rvalid = 1'b0;
    memIf.mem_rdata = 32'b0;

    // Reset values
    repeat (2) step();
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_fault", 32'(fault), 32'd0);
    checkOutput("rst_rdata", rdata, 32'd0);
    checkOutput("rst_req", 32'(memIf.mem_req), 32'd0);
    checkOutput("rst_we", 32'(memIf.mem_we), 32'd0);
    checkOutput("rst_addr", memIf.mem_addr, 32'd0);
    checkOutput("rst_be", 32'(memIf.mem_be), 32'd0);
    checkOutput("rst_wdata", memIf.mem_wdata, 32'd0);
    rst_n = 1'b1;
    checkEn = 1'b1;
    step();

    // Store byte to lane 3 with immediate grant
    applyStimulus(1'b1, MEMOP_B, 32'h0000_1003, 32'h0000_00A5, 0, 0, 32'h0, 1'b0);
    checkOutput("sb_addr", capAddr, 32'h0000_1000);
    checkOutput("sb_be", 32'(capBe), 32'h8);
    checkOutput("sb_wdata", capWdata, 32'hA5A5_A5A5);
    checkOutput("sb_latency", 32'(lastDoneCycle - startCycle), 32'd2);
    checkOutput("sb_fault", 32'(fault), 32'd0);

    // Signed and unsigned half loads, response three cycles after grant
    applyStimulus(1'b0, MEMOP_H, 32'h0000_2002, 32'h0, 0, 3, 32'h8001_1234, 1'b0);
    checkOutput("lh_rdata", rdata, 32'hFFFF_8001);
    checkOutput("lh_latency", 32'(lastDoneCycle - startCycle), 32'd5);
    applyStimulus(1'b0, MEMOP_HU, 32'h0000_2002, 32'h0, 0, 3, 32'h8001_1234, 1'b0);
    checkOutput("lhu_rdata", rdata, 32'h0000_8001);

    // Misaligned word and illegal MemOp fault without a memory request
    reqSeen = 1'b0;
    applyStimulus(1'b0, MEMOP_W, 32'h0000_3001, 32'h0, 0, 1, 32'h0, 1'b0);
    checkOutput("lw_mis_latency", 32'(lastDoneCycle - startCycle), 32'd1);
    checkOutput("lw_mis_fault", 32'(fault), 32'd1);
    checkOutput("lw_mis_rdata", rdata, 32'h0000_8001);
    applyStimulus(1'b1, 3'b111, 32'h0000_3000, 32'h1111_2222, 0, 1, 32'h0, 1'b0);
    checkOutput("op111_fault", 32'(fault), 32'd1);
    checkOutput("fault_no_req", 32'(reqSeen), 32'd0);

    // Half store stalled four cycles on grant, with a start pulse during the stall
    applyStimulus(1'b1, MEMOP_H, 32'h0000_2006, 32'hBEEF_1234, 4, 0, 32'h0, 1'b1);
    checkOutput("stall_be", 32'(capBe), 32'hC);
    checkOutput("stall_latency", 32'(lastDoneCycle - startCycle), 32'd6);

    // Signed byte from lane 3 after a one-cycle grant stall with a stray rvalid
    applyStimulus(1'b0, MEMOP_B, 32'h0000_0103, 32'h0, 1, 1, 32'h80FF_0000, 1'b0);
    checkOutput("lb_rdata", rdata, 32'hFFFF_FF80);

    // Word load passes through; word store with a short stall
    applyStimulus(1'b0, MEMOP_W, 32'h0000_0200, 32'h0, 0, 2, 32'h89AB_CDEF, 1'b0);
    checkOutput("lw_rdata", rdata, 32'h89AB_CDEF);
    applyStimulus(1'b1, MEMOP_W, 32'h0000_0300, 32'hCAFE_F00D, 2, 0, 32'h0, 1'b0);

    // Reset while waiting for the read response; the late response is dropped
    MemWr = 1'b0; MemOp = MEMOP_W; addr = 32'h0000_5000; start = 1'b1;
    step();
    start = 1'b0;
    eBusy = 1'b1; eReq = 1'b1; eWe = 1'b0; eAddr = 32'h0000_5000; eBe = 4'hF;
    memIf.mem_gnt = 1'b1;
    step();
    memIf.mem_gnt = 1'b0;
    eReq = 1'b0;
    rst_n = 1'b0;
    eBusy = 1'b0; eRdata = 32'b0; eFault = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    memIf.mem_rvalid = 1'b1;
    memIf.mem_rdata = 32'hDEAD_BEEF;
    firstDone = lastDoneCycle;
    step();
    memIf.mem_rvalid = 1'b0;
    repeat (2) step();
    checkOutput("rstwait_no_done", 32'(lastDoneCycle), 32'(firstDone));
    checkOutput("rstwait_rdata", rdata, 32'd0);

    // Reset while requesting drops mem_req at once
    MemWr = 1'b1; MemOp = MEMOP_W; addr = 32'h0000_6000; wdata = 32'h0BAD_F00D; start = 1'b1;
    step();
    start = 1'b0;
    eBusy = 1'b1; eReq = 1'b1; eWe = 1'b1; eAddr = 32'h0000_6000; eBe = 4'hF; eWdata = 32'h0BAD_F00D;
    rst_n = 1'b0;
    eBusy = 1'b0; eReq = 1'b0; eWe = 1'b0;
    #1;
    checkOutput("rstreq_drop", 32'(memIf.mem_req), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // Back-to-back: word store, then byte-unsigned load the cycle after done
    applyStimulus(1'b1, MEMOP_W, 32'h0000_4000, 32'h1234_5678, 0, 0, 32'h0, 1'b0);
    firstDone = lastDoneCycle;
    applyStimulus(1'b0, MEMOP_BU, 32'h0000_4001, 32'h0, 0, 1, 32'h0000_FF00, 1'b0);
    checkOutput("b2b_gap", 32'(startCycle - firstDone), 32'd1);
    checkOutput("b2b_latency", 32'(lastDoneCycle - startCycle), 32'd3);
    checkOutput("b2b_rdata", rdata, 32'h0000_00FF);

    step();
    checkEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
